// File: rtl/watch_mode_controller_if.sv
// ============================================================================
// Module  : watch_mode_controller_if
// Brief   : Button/switch inputs and indicator/strobe outputs of the watch
//           mode controller.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface watch_mode_controller_if;
  logic       i_up;
  logic       i_down;
  logic       i_left;
  logic       i_right;
  logic       i_watch_select;
  logic       i_edit;
  logic       o_run_stop;
  logic       o_clear;
  logic [1:0] o_edit_msec;
  logic [1:0] o_edit_sec;
  logic [1:0] o_edit_min;
  logic [1:0] o_edit_hour;
  logic [3:0] LED;

  modport master (
    output i_up, i_down, i_left, i_right, i_watch_select, i_edit,
    input  o_run_stop, o_clear, o_edit_msec, o_edit_sec, o_edit_min,
           o_edit_hour, LED
  );

  modport slave (
    input  i_up, i_down, i_left, i_right, i_watch_select, i_edit,
    output o_run_stop, o_clear, o_edit_msec, o_edit_sec, o_edit_min,
           o_edit_hour, LED
  );
endinterface

`default_nettype wire

// File: rtl/watch_mode_controller.sv
// ============================================================================
// Module  : watch_mode_controller
// Brief   : Stopwatch run/stop/clear FSM, watch edit FSM with field pointer,
//           up/down edit strobes with auto-repeat, and indicator LEDs.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module watch_mode_controller #(
  parameter int HOLD_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000
) (
  input  wire logic             clk,
  input  wire logic             reset,
  watch_mode_controller_if.slave bus
);

  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    SW_STOP  = 2'd0,
    SW_RUN   = 2'd1,
    SW_CLEAR = 2'd2
  } sw_state_t;

  typedef enum logic {
    ED_NORMAL = 1'b0,
    ED_EDIT   = 1'b1
  } ed_state_t;

  sw_state_t        sw_q, sw_d;
  ed_state_t        ed_q, ed_d;
  logic [3:0]       prev_q;
  logic [1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;
  logic             active_q, active_d;
  logic             dir_dn_q, dir_dn_d;
  logic             run_q, run_d;
  logic             clr_q, clr_d;
  logic [3:0][1:0]  edit_q, edit_d;
  logic [3:0]       led_q, led_d;

  logic [3:0] w_lvl;
  logic [3:0] w_ev;
  logic       w_up_ev, w_dn_ev, w_left_ev, w_right_ev;
  logic       w_in_edit;
  logic       w_strobe, w_strobe_dn;

  assign w_lvl      = {bus.i_up, bus.i_down, bus.i_left, bus.i_right};
  assign w_ev       = w_lvl & ~prev_q;
  assign w_up_ev    = w_ev[3];
  assign w_dn_ev    = w_ev[2];
  assign w_left_ev  = w_ev[1];
  assign w_right_ev = w_ev[0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sw_q     <= SW_STOP;
      ed_q     <= ED_NORMAL;
      prev_q   <= '0;
      ptr_q    <= 2'd1;
      cnt_q    <= '0;
      phase_q  <= 1'b0;
      active_q <= 1'b0;
      dir_dn_q <= 1'b0;
      run_q    <= 1'b0;
      clr_q    <= 1'b0;
      edit_q   <= '0;
      led_q    <= '0;
    end else begin
      sw_q     <= sw_d;
      ed_q     <= ed_d;
      prev_q   <= w_lvl;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
      active_q <= active_d;
      dir_dn_q <= dir_dn_d;
      run_q    <= run_d;
      clr_q    <= clr_d;
      edit_q   <= edit_d;
      led_q    <= led_d;
    end
  end

  always_comb begin
    sw_d = sw_q;
    unique case (sw_q)
      SW_STOP: begin
        if (bus.i_watch_select && w_right_ev)     sw_d = SW_RUN;
        else if (bus.i_watch_select && w_left_ev) sw_d = SW_CLEAR;
      end
      SW_RUN: begin
        if (bus.i_watch_select && w_right_ev) sw_d = SW_STOP;
      end
      SW_CLEAR: sw_d = SW_STOP;
      default:  sw_d = SW_STOP;
    endcase
  end

  always_comb begin
    ed_d  = ed_q;
    ptr_d = ptr_q;
    unique case (ed_q)
      ED_NORMAL: begin
        if (bus.i_edit && !bus.i_watch_select) begin
          ed_d  = ED_EDIT;
          ptr_d = 2'd1;
        end
      end
      ED_EDIT: begin
        if (!bus.i_edit || bus.i_watch_select) begin
          ed_d = ED_NORMAL;
        end else if (w_left_ev && !w_right_ev) begin
          ptr_d = ptr_q + 2'd1;
        end else if (w_right_ev && !w_left_ev) begin
          ptr_d = ptr_q - 2'd1;
        end
      end
      default: ed_d = ED_NORMAL;
    endcase
  end

  // Strobes only while EDIT is both current and retained this cycle.
  assign w_in_edit = (ed_q == ED_EDIT) && (ed_d == ED_EDIT);

  always_comb begin
    w_strobe    = 1'b0;
    w_strobe_dn = 1'b0;
    cnt_d       = cnt_q;
    phase_d     = phase_q;
    active_d    = active_q;
    dir_dn_d    = dir_dn_q;
    if (!w_in_edit || (bus.i_up && bus.i_down)) begin
      cnt_d    = '0;
      phase_d  = 1'b0;
      active_d = 1'b0;
    end else if (w_up_ev || w_dn_ev) begin
      w_strobe    = 1'b1;
      w_strobe_dn = w_dn_ev;
      dir_dn_d    = w_dn_ev;
      active_d    = 1'b1;
      cnt_d       = '0;
      phase_d     = 1'b0;
    end else if (active_q && (dir_dn_q ? bus.i_down : bus.i_up)) begin
      if ((!phase_q && cnt_q == HOLD_LAST) || (phase_q && cnt_q == REPEAT_LAST)) begin
        w_strobe    = 1'b1;
        w_strobe_dn = dir_dn_q;
        cnt_d       = '0;
        phase_d     = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      cnt_d    = '0;
      phase_d  = 1'b0;
      active_d = 1'b0;
    end
  end

  always_comb begin
    run_d  = (sw_d == SW_RUN);
    clr_d  = (sw_d == SW_CLEAR);
    edit_d = '0;
    if (w_strobe) begin
      edit_d[ptr_d] = w_strobe_dn ? 2'b11 : 2'b01;
    end
    led_d = 4'b0000;
    if (bus.i_watch_select) begin
      led_d = {3'b000, (sw_d == SW_RUN)};
    end else if (ed_d == ED_EDIT) begin
      led_d = 4'b0001 << ptr_d;
    end
  end

  assign bus.o_run_stop  = run_q;
  assign bus.o_clear     = clr_q;
  assign bus.o_edit_msec = edit_q[0];
  assign bus.o_edit_sec  = edit_q[1];
  assign bus.o_edit_min  = edit_q[2];
  assign bus.o_edit_hour = edit_q[3];
  assign bus.LED         = led_q;

endmodule

`default_nettype wire

// File: tb/tb_watch_mode_controller.sv
// ============================================================================
// Module  : tb_watch_mode_controller
// Brief   : Directed vector table plus hand sequences for auto-repeat and reset.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_watch_mode_controller;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_pass;

  watch_mode_controller_if bus ();

  watch_mode_controller #(
    .HOLD_CYCLES   (8),
    .REPEAT_CYCLES (4)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       sel, edit, up, down, left, right;
    logic       run, clr;
    logic [1:0] ms, s, mn, hr;
    logic [3:0] led;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(input logic sel, edit, up, down, left, right,
                             input logic run, clr,
                             input logic [1:0] ms, s, mn, hr,
                             input logic [3:0] led);
    vec_t r;
    r.sel = sel; r.edit = edit; r.up = up; r.down = down;
    r.left = left; r.right = right; r.run = run; r.clr = clr;
    r.ms = ms; r.s = s; r.mn = mn; r.hr = hr; r.led = led;
    return r;
  endfunction

  function automatic logic [13:0] outs();
    return {bus.o_run_stop, bus.o_clear, bus.o_edit_msec, bus.o_edit_sec,
            bus.o_edit_min, bus.o_edit_hour, bus.LED};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic sel, edit, up, down, left, right);
    bus.i_watch_select = sel;
    bus.i_edit         = edit;
    bus.i_up           = up;
    bus.i_down         = down;
    bus.i_left         = left;
    bus.i_right        = right;
  endtask

  // Up held for hold_len edges from event edge 0, edit kept for edit_len edges.
  task automatic run_hold(input int hold_len, input int edit_len, input int ncyc,
                          input int exp_cnt, input string nm);
    int         strobes;
    logic [1:0] exp_s;
    strobes = 0;
    for (int j = 0; j < ncyc; j++) begin
      drive(1'b0, (j < edit_len), (j < hold_len), 1'b0, 1'b0, 1'b0);
      step();
      exp_s = ((j < hold_len) && (j < edit_len) &&
               (j == 0 || (j >= 8 && ((j - 8) % 4) == 0))) ? 2'b01 : 2'b00;
      chk($sformatf("%s_sec_e%0d", nm, j), 32'(bus.o_edit_sec), 32'(exp_s));
      chk($sformatf("%s_led_e%0d", nm, j), 32'(bus.LED),
          (j < edit_len) ? 32'h2 : 32'h0);
      if (bus.o_edit_sec == 2'b01) strobes++;
    end
    bus.i_up = 1'b0;
    chk($sformatf("%s_count", nm), 32'(strobes), 32'(exp_cnt));
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    reset  = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Stopwatch run/stop/clear
    vecs.push_back(v(1,0,0,0,0,0, 0,0, 0,0,0,0, 4'b0000));
    vecs.push_back(v(1,0,0,0,0,1, 1,0, 0,0,0,0, 4'b0001));
    vecs.push_back(v(1,0,0,0,0,0, 1,0, 0,0,0,0, 4'b0001));
    vecs.push_back(v(1,0,0,0,1,0, 1,0, 0,0,0,0, 4'b0001));
    vecs.push_back(v(1,0,0,0,0,0, 1,0, 0,0,0,0, 4'b0001));
    vecs.push_back(v(1,0,0,0,0,1, 0,0, 0,0,0,0, 4'b0000));
    vecs.push_back(v(1,0,0,0,0,0, 0,0, 0,0,0,0, 4'b0000));
    vecs.push_back(v(1,0,0,0,1,0, 0,1, 0,0,0,0, 4'b0000));
    vecs.push_back(v(1,0,0,0,0,0, 0,0, 0,0,0,0, 4'b0000));
    // Watch NORMAL ignores buttons
    vecs.push_back(v(0,0,0,0,0,1, 0,0, 0,0,0,0, 4'b0000));
    vecs.push_back(v(0,0,0,0,0,0, 0,0, 0,0,0,0, 4'b0000));
    vecs.push_back(v(0,0,0,0,1,0, 0,0, 0,0,0,0, 4'b0000));
    vecs.push_back(v(0,0,0,0,0,0, 0,0, 0,0,0,0, 4'b0000));
    vecs.push_back(v(0,0,1,0,0,0, 0,0, 0,0,0,0, 4'b0000));
    vecs.push_back(v(0,0,0,0,0,0, 0,0, 0,0,0,0, 4'b0000));
    // RUN persists across select 1->0->1
    vecs.push_back(v(1,0,0,0,0,1, 1,0, 0,0,0,0, 4'b0001));
    vecs.push_back(v(1,0,0,0,0,0, 1,0, 0,0,0,0, 4'b0001));
    vecs.push_back(v(0,0,0,0,0,0, 1,0, 0,0,0,0, 4'b0000));
    vecs.push_back(v(1,0,0,0,0,0, 1,0, 0,0,0,0, 4'b0001));
    vecs.push_back(v(1,0,0,0,0,1, 0,0, 0,0,0,0, 4'b0000));
    // Stopwatch mode blocks edit
    vecs.push_back(v(1,1,0,0,0,0, 0,0, 0,0,0,0, 4'b0000));
    vecs.push_back(v(1,1,1,0,0,0, 0,0, 0,0,0,0, 4'b0000));
    vecs.push_back(v(1,1,0,0,0,0, 0,0, 0,0,0,0, 4'b0000));
    // Edit navigation
    vecs.push_back(v(0,1,0,0,0,0, 0,0, 0,0,0,0, 4'b0010));
    vecs.push_back(v(0,1,0,0,1,0, 0,0, 0,0,0,0, 4'b0100));
    vecs.push_back(v(0,1,0,0,0,0, 0,0, 0,0,0,0, 4'b0100));
    vecs.push_back(v(0,1,0,0,1,0, 0,0, 0,0,0,0, 4'b1000));
    vecs.push_back(v(0,1,0,0,0,0, 0,0, 0,0,0,0, 4'b1000));
    vecs.push_back(v(0,1,0,0,1,0, 0,0, 0,0,0,0, 4'b0001));
    vecs.push_back(v(0,1,0,0,0,0, 0,0, 0,0,0,0, 4'b0001));
    vecs.push_back(v(0,1,0,0,0,1, 0,0, 0,0,0,0, 4'b1000));
    vecs.push_back(v(0,1,0,0,0,0, 0,0, 0,0,0,0, 4'b1000));
    vecs.push_back(v(0,1,0,0,1,1, 0,0, 0,0,0,0, 4'b1000));
    vecs.push_back(v(0,1,0,0,0,0, 0,0, 0,0,0,0, 4'b1000));
    vecs.push_back(v(0,1,0,0,0,1, 0,0, 0,0,0,0, 4'b0100));
    vecs.push_back(v(0,1,0,0,0,0, 0,0, 0,0,0,0, 4'b0100));
    // Edit strobes on min
    vecs.push_back(v(0,1,1,0,0,0, 0,0, 0,0,1,0, 4'b0100));
    vecs.push_back(v(0,1,0,0,0,0, 0,0, 0,0,0,0, 4'b0100));
    vecs.push_back(v(0,1,0,1,0,0, 0,0, 0,0,3,0, 4'b0100));
    vecs.push_back(v(0,1,0,0,0,0, 0,0, 0,0,0,0, 4'b0100));
    vecs.push_back(v(0,1,1,1,0,0, 0,0, 0,0,0,0, 4'b0100));
    vecs.push_back(v(0,1,0,0,0,0, 0,0, 0,0,0,0, 4'b0100));
    vecs.push_back(v(0,0,0,0,0,0, 0,0, 0,0,0,0, 4'b0000));

    // Reset state, held low across several edges
    #2 reset = 1'b0;
    #1 chk("reset_async", 32'(outs()), 32'h0);
    repeat (3) step();
    chk("reset_hold", 32'(outs()), 32'h0);
    reset = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].sel, vecs[i].edit, vecs[i].up, vecs[i].down,
            vecs[i].left, vecs[i].right);
      step();
      chk($sformatf("vec%0d", i), 32'(outs()),
          32'({vecs[i].run, vecs[i].clr, vecs[i].ms, vecs[i].s,
               vecs[i].mn, vecs[i].hr, vecs[i].led}));
    end

    // Auto-repeat on sec
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk("edit_entry_led", 32'(bus.LED), 32'h2);
    run_hold(20, 1000, 24, 4, "hold20");
    run_hold(14, 1000, 18, 3, "rel14");
    run_hold(1000, 10, 16, 2, "drop10");
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();

    // Reset during RUN with up held in EDIT, asserted on a repeat-strobe cycle
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    chk("pre_reset_run", 32'(bus.o_run_stop), 32'h1);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    bus.i_up = 1'b1;
    for (int j = 0; j <= 8; j++) step();
    chk("pre_reset_strobe", 32'(outs()), 32'({1'b1, 1'b0, 8'b00_01_00_00, 4'b0010}));
    #3 reset = 1'b0;
    #1 chk("reset_mid_async", 32'(outs()), 32'h0);
    step();
    step();
    chk("reset_mid_hold", 32'(outs()), 32'h0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    reset = 1'b1;
    step();
    chk("reset_release_run", 32'(bus.o_run_stop), 32'h1);
    chk("reset_release_led", 32'(bus.LED), 32'h1);
    bus.i_right = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/watch_mode_controller.md
# watch_mode_controller

Sequencing controller for the combined watch/stopwatch datapath. It turns debounced push-button levels and mode switches into the stopwatch run/stop level, the stopwatch clear pulse, and per-field watch edit strobes (2'b01 = step up, 2'b11 = step down, 2'b00 = idle). It also provides auto-repeat for held up/down buttons and drives the mode/field indicator LEDs. It sits between the button debouncers and the watch and stopwatch datapaths.

## Interface
- HOLD_CYCLES, 50_000_000: cycles a held up/down button must stay held before auto-repeat starts (0.5 s at 100 MHz).
- REPEAT_CYCLES, 10_000_000: cycles between auto-repeat strobes (0.1 s).
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- i_up, i_down, i_left, i_right  in  1 each  debounced button levels, active high.
- i_watch_select  in  1  0 = watch mode, 1 = stopwatch mode.
- i_edit  in  1  1 = request watch edit mode.
- o_run_stop  out  1  stopwatch run level.
- o_clear  out  1  stopwatch clear, one-cycle pulse.
- o_edit_msec, o_edit_sec, o_edit_min, o_edit_hour  out  2 each  edit strobe for that field.
- LED  out  4  indicator.

## Operation
- Edge detect: one registered previous-value flop per button. A button event is (level & ~prev). Prev flops reset to 0.
- Stopwatch FSM (STOP, RUN, CLEAR). Button events act on it only when i_watch_select=1.
  - STOP: right → RUN. Left → CLEAR.
  - RUN: right → STOP. Left is ignored.
  - CLEAR: lasts one cycle, o_clear=1, then → STOP unconditionally.
  - The FSM keeps its state and keeps running while watch mode is displayed.
- o_run_stop = (state==RUN). It is low in STOP and CLEAR.
- Edit FSM (NORMAL, EDIT).
  - NORMAL → EDIT when i_edit=1 & i_watch_select=0. On entry the field pointer loads 1 (sec).
  - EDIT → NORMAL when i_edit=0 or i_watch_select=1.
- Field pointer (2 bits, 0=msec, 1=sec, 2=min, 3=hour), EDIT only:
  - Left event: +1, wraps 3→0.
  - Right event: −1, wraps 0→3.
  - Left and right events in the same cycle: both ignored.
- Edit strobes, EDIT only: an up event drives 2'b01 on the selected field output for one cycle. A down event drives 2'b11. All other field outputs stay 2'b00.
- Up and down events in the same cycle, or both levels high: no strobe, and the repeat counter is cleared.
- Auto-repeat counter, width $clog2(HOLD_CYCLES), EDIT only:
  - Clears on the up/down event and counts while the same single button stays high.
  - At count HOLD_CYCLES−1: strobe, enter repeat phase, reload 0.
  - In repeat phase, at count REPEAT_CYCLES−1: strobe, reload 0.
  - Release, the other button pressed, or leaving EDIT: counter and phase cleared, strobes stop immediately.
- Pointer movement during a held up/down retargets subsequent repeat strobes to the new field. The counter is not cleared.
- LED:
  - Stopwatch mode: {3'b000, o_run_stop}.
  - Watch NORMAL: 4'b0000.
  - Watch EDIT: one-hot of the pointer, LED[0]=msec … LED[3]=hour.
- Mode switches are used combinationally with the same-edge button event. Switch settings must be stable ≥1 cycle for defined behaviour at the transition.

## Timing
- All outputs are registered.
- Latency: a button first sampled high at edge k produces its output effect (strobe, o_clear, o_run_stop change, pointer/LED change) immediately after edge k. Strobes are exactly one cycle wide.
- o_clear is high for the single cycle after the left event. o_run_stop is 0 during that cycle.
- Reset (asynchronous, reset=0), all values hold while reset is low:
  - Stopwatch FSM = STOP, edit FSM = NORMAL, pointer = 1, repeat logic cleared.
  - o_run_stop=0, o_clear=0, all edit outputs 2'b00, LED=4'b0000.
- A button held across reset deassertion registers an event at the first clock edge.
- Reset asserted mid-run or mid-repeat: no strobe may be emitted after assertion.
- Auto-repeat strobes relative to the event cycle E: E, E+HOLD_CYCLES, E+HOLD_CYCLES+REPEAT_CYCLES, and so on.

## Test plan
All scenarios use HOLD_CYCLES=8 and REPEAT_CYCLES=4.
- Stopwatch run/stop/clear: sw select=1, right pulse → o_run_stop=1 next cycle, LED=4'b0001. Left pulse while running → no o_clear. Right → o_run_stop=0. Left → o_clear high exactly 1 cycle, LED=4'b0000.
- Edit navigation: select=0, i_edit=1 → LED=4'b0010. Left×3 → LED 0100, 1000, 0001 (wrap). Right → LED=4'b1000. Simultaneous left+right → LED unchanged.
- Edit strobe: pointer=min, up pulse → o_edit_min=2'b01 for 1 cycle, others 2'b00. Down pulse → o_edit_min=2'b11 for 1 cycle. Up+down same cycle → no strobe.
- Auto-repeat: hold up 20 cycles on sec → o_edit_sec=2'b01 at E, E+8, E+12, E+16 (4 strobes). Release at E+14 → only 3 strobes. Drop i_edit at E+10 → LED=4'b0000 and no further strobes.
- Mode isolation: in watch NORMAL, right/left/up produce no output change. Select=1 with i_edit=1 → no edit strobes. Stopwatch RUN persists across select 1→0→1.
- Reset: assert reset=0 during RUN with up held in EDIT → all outputs 0 asynchronously, before the next edge. Release with right held → o_run_stop=1 after first edge (in stopwatch mode).
